// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 4-bit combinational ALU between two valid/ready
// requesters. Each accepted operation is registered, executed, and returned
// on a single response channel tagged with the originating requester.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   req{0,1}_valid/_ready             request handshake per requester
//   req{0,1}_a/_b (4b), req{0,1}_op   operands and opcode
//   rsp_valid/rsp_ready               response handshake
//   rsp_id, rsp_result, rsp_carry,    tagged ALU result and flags
//   rsp_zero
//   busy                              high whenever not idle
// Build option: define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority.
module alu_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       grant_id;
    logic       accept;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [2:0] op_q;
    logic       id_q;
    logic [4:0] alu_wide;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       alu_zero;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Requester granted at the most recent accept; reset to 1 so
    // requester 0 wins the first contention.
    logic last_grant;

    always_comb begin
        if (req0_valid && req1_valid)
            grant_id = ~last_grant;
        else
            grant_id = req1_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant_id;
    end
`else
    always_comb begin
        grant_id = req1_valid & ~req0_valid;
    end
`endif

    assign req0_ready = (state == IDLE) && req0_valid && !grant_id;
    assign req1_ready = (state == IDLE) && req1_valid && grant_id;
    assign accept     = req0_ready | req1_ready;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shared ALU. Subtraction is done 5 bits wide so bit 4 is the borrow.
    always_comb begin
        alu_wide = 5'd0;
        unique case (op_q)
            3'b000:  alu_wide = {1'b0, a_q} + {1'b0, b_q};
            3'b001:  alu_wide = {1'b0, a_q} - {1'b0, b_q};
            3'b010:  alu_wide = {1'b0, a_q & b_q};
            3'b011:  alu_wide = {1'b0, a_q | b_q};
            3'b100:  alu_wide = {1'b0, ~a_q};
            default: alu_wide = 5'd0;
        endcase
        alu_result = alu_wide[3:0];
        alu_carry  = alu_wide[4];
        alu_zero   = (alu_wide[3:0] == 4'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= 4'd0;
            b_q  <= 4'd0;
            op_q <= 3'd0;
            id_q <= 1'b0;
        end else if (accept) begin
            a_q  <= grant_id ? req1_a  : req0_a;
            b_q  <= grant_id ? req1_b  : req0_b;
            op_q <= grant_id ? req1_op : req0_op;
            id_q <= grant_id;
        end
    end

    // Response registers hold their value after consumption; only
    // rsp_valid is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= 4'd0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
        end else if (state == EXEC) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= id_q;
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_zero   <= alu_zero;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter; table vectors,
// hand-written corner sequences and random traffic against a reference model.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready;
    logic [3:0] req0_a, req0_b;
    logic [2:0] req0_op;
    logic       req1_valid, req1_ready;
    logic [3:0] req1_a, req1_b;
    logic [2:0] req1_op;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [3:0] rsp_result;
    logic       rsp_carry, rsp_zero, busy;

    int checks   = 0;
    int failures = 0;
    bit model_last;

    typedef struct {
        logic       id;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] res;
        logic       c;
        logic       z;
    } vec_t;

    typedef struct {
        logic       id;
        logic [3:0] res;
        logic       c;
        logic       z;
    } exp_t;

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference ALU from the opcode table, using integer arithmetic.
    function automatic exp_t alu_model(input logic id, input logic [3:0] a,
                                       input logic [3:0] b, input logic [2:0] op);
        exp_t e;
        int   r;
        case (op)
            3'd0:    r = int'(a) + int'(b);
            3'd1:    r = int'(a) - int'(b);
            3'd2:    r = int'(a & b);
            3'd3:    r = int'(a | b);
            3'd4:    r = 15 - int'(a);
            default: r = 0;
        endcase
        if (r < 0) r = r + 32;
        e.id  = id;
        e.res = r[3:0];
        e.c   = r[4];
        e.z   = (r[3:0] == 4'd0);
        return e;
    endfunction

    // Arbitration rule: which requester wins given the valids.
    function automatic bit model_win(input bit v0, input bit v1, input bit last);
`ifdef ALU_ARB_ROUND_ROBIN_EN
        if (v0 && v1) return !last;
        return v1;
`else
        return v1 && !v0;
`endif
    endfunction

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0; req0_op = 3'd0;
        req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0; req1_op = 3'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1;
    endtask

    task automatic drive(input logic id, input logic [3:0] a,
                         input logic [3:0] b, input logic [2:0] op);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    // One lone-requester operation with exact cycle-by-cycle timing checks.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive(v.id, v.a, v.b, v.op);
        rsp_ready = 1'b1;
        #1;
        chk({tag, "_ready"}, int'(v.id ? req1_ready : req0_ready), 1);
        chk({tag, "_other_ready"}, int'(v.id ? req0_ready : req1_ready), 0);
        @(posedge clk);
        #1;
        idle_inputs();
        model_last = v.id;
        @(negedge clk);
        chk({tag, "_exec_busy"}, int'(busy), 1);
        chk({tag, "_exec_valid"}, int'(rsp_valid), 0);
        @(negedge clk);
        chk({tag, "_valid"}, int'(rsp_valid), 1);
        chk({tag, "_busy"}, int'(busy), 1);
        chk({tag, "_id"}, int'(rsp_id), int'(v.id));
        chk({tag, "_result"}, int'(rsp_result), int'(v.res));
        chk({tag, "_carry"}, int'(rsp_carry), int'(v.c));
        chk({tag, "_zero"}, int'(rsp_zero), int'(v.z));
        @(negedge clk);
        chk({tag, "_done_valid"}, int'(rsp_valid), 0);
        chk({tag, "_done_busy"}, int'(busy), 0);
    endtask

    vec_t tbl[10];
    exp_t exp_q[$];

    initial begin
        exp_t  e;
        bit    w;
        bit    r1seen;
        int    nrsp;
        bit    pv[2];
        logic [3:0] pa[2], pb[2];
        logic [2:0] po[2];
        bit    outstanding;
        bit    idle_now;
        bit    consumed;
        int    age;

        tbl[0] = '{1'b0, 4'd5,  4'd3,  3'd0, 4'd8,  1'b0, 1'b0};
        tbl[1] = '{1'b1, 4'd3,  4'd5,  3'd1, 4'hE,  1'b1, 1'b0};
        tbl[2] = '{1'b1, 4'd9,  4'd9,  3'd1, 4'd0,  1'b0, 1'b1};
        tbl[3] = '{1'b0, 4'hF,  4'd0,  3'd4, 4'd0,  1'b0, 1'b1};
        tbl[4] = '{1'b0, 4'd7,  4'd7,  3'd6, 4'd0,  1'b0, 1'b1};
        tbl[5] = '{1'b1, 4'hC,  4'hA,  3'd2, 4'd8,  1'b0, 1'b0};
        tbl[6] = '{1'b0, 4'hC,  4'hA,  3'd3, 4'hE,  1'b0, 1'b0};
        tbl[7] = '{1'b1, 4'hF,  4'd1,  3'd0, 4'd0,  1'b1, 1'b1};
        tbl[8] = '{1'b0, 4'd6,  4'd2,  3'd7, 4'd0,  1'b0, 1'b1};
        tbl[9] = '{1'b1, 4'hA,  4'd5,  3'd4, 4'd5,  1'b0, 1'b0};

        idle_inputs();
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        model_last = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req0_ready", int'(req0_ready), 0);
        chk("rst_req1_ready", int'(req1_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_result", int'(rsp_result), 0);
        chk("rst_rsp_carry", int'(rsp_carry), 0);
        chk("rst_rsp_zero", int'(rsp_zero), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        // Contention: both valid every cycle for four operations.
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_op = 3'd0;
        req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2; req1_op = 3'd0;
        rsp_ready = 1'b1;
        nrsp = 0;
        r1seen = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 40 && nrsp < 4; i++) begin
            #1;
            if (req1_ready) r1seen = 1'b1;
            if (req0_ready || req1_ready) begin
                w = model_win(1'b1, 1'b1, model_last);
                chk("cont_grant", int'(req1_ready), int'(w));
                chk("cont_onehot", int'(req0_ready & req1_ready), 0);
                exp_q.push_back(alu_model(w, w ? 4'd2 : 4'd1, w ? 4'd2 : 4'd1, 3'd0));
                model_last = w;
            end
            if (rsp_valid) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("cont_id", int'(rsp_id), int'(e.id));
                    chk("cont_result", int'(rsp_result), int'(e.res));
                end else begin
                    chk("cont_unexpected_rsp", int'(rsp_valid), 0);
                end
                nrsp++;
            end
            @(negedge clk);
        end
        idle_inputs();
        chk("cont_count", nrsp, 4);
`ifndef ALU_ARB_ROUND_ROBIN_EN
        chk("cont_req1_never_ready", int'(r1seen), 0);
`endif
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        // Backpressure: stall the response for five cycles.
        @(negedge clk);
        drive(1'b0, 4'hF, 4'd0, 3'd4);
        rsp_ready = 1'b0;
        #1;
        chk("bp_accept", int'(req0_ready), 1);
        @(posedge clk);
        #1;
        idle_inputs();
        model_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 4'd1, 4'd2, 3'd0);
        drive(1'b1, 4'd4, 4'd1, 3'd1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", int'(rsp_valid), 1);
            chk("bp_result", int'(rsp_result), 0);
            chk("bp_zero", int'(rsp_zero), 1);
            chk("bp_carry", int'(rsp_carry), 0);
            chk("bp_id", int'(rsp_id), 0);
            chk("bp_req0_ready", int'(req0_ready), 0);
            chk("bp_req1_ready", int'(req1_ready), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        w = model_win(1'b1, 1'b1, model_last);
        chk("bp_next_valid", int'(rsp_valid), 0);
        chk("bp_next_busy", int'(busy), 0);
        chk("bp_next_req0_ready", int'(req0_ready), int'(!w));
        chk("bp_next_req1_ready", int'(req1_ready), int'(w));
        @(posedge clk);
        #1;
        idle_inputs();
        model_last = w;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_rsp_valid", int'(rsp_valid), 1);
        chk("bp_next_rsp_id", int'(rsp_id), int'(w));
        chk("bp_next_rsp_result", int'(rsp_result), 3);
        @(negedge clk);

        // Reset in the middle of an operation.
        @(negedge clk);
        drive(1'b0, 4'd5, 4'd3, 3'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_valid", int'(rsp_valid), 0);
        chk("mid_rst_result", int'(rsp_result), 0);
        chk("mid_rst_id", int'(rsp_id), 0);
        chk("mid_rst_carry", int'(rsp_carry), 0);
        chk("mid_rst_zero", int'(rsp_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", int'(rsp_valid), 0);
            chk("post_rst_idle", int'(busy), 0);
        end
        drive(1'b0, 4'd2, 4'd1, 3'd1);
        drive(1'b1, 4'd6, 4'd6, 3'd0);
        #1;
        chk("post_rst_req0_wins", int'(req0_ready), 1);
        chk("post_rst_req1_loses", int'(req1_ready), 0);
        @(posedge clk);
        #1;
        idle_inputs();
        model_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_rsp_id", int'(rsp_id), 0);
        chk("post_rst_rsp_result", int'(rsp_result), 1);

        // Random traffic against the reference model.
        do_reset();
        exp_q.delete();
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        outstanding = 1'b0;
        age = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (!pv[r] && $urandom_range(0, 2) != 0) begin
                    pv[r] = 1'b1;
                    pa[r] = 4'($urandom);
                    pb[r] = 4'($urandom);
                    po[r] = 3'($urandom);
                end
            end
            req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = po[0];
            req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = po[1];
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (outstanding) age++;
            idle_now = !outstanding;
            consumed = 1'b0;
            chk("rnd_rsp_valid", int'(rsp_valid), int'(outstanding && age >= 2));
            if (outstanding && age >= 2 && rsp_valid && exp_q.size() > 0) begin
                e = exp_q[0];
                chk("rnd_id", int'(rsp_id), int'(e.id));
                chk("rnd_result", int'(rsp_result), int'(e.res));
                chk("rnd_carry", int'(rsp_carry), int'(e.c));
                chk("rnd_zero", int'(rsp_zero), int'(e.z));
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    consumed = 1'b1;
                end
            end
            if (idle_now && (pv[0] || pv[1])) begin
                w = model_win(pv[0], pv[1], model_last);
                chk("rnd_req0_ready", int'(req0_ready), int'(!w));
                chk("rnd_req1_ready", int'(req1_ready), int'(w));
                exp_q.push_back(alu_model(w, pa[w], pb[w], po[w]));
                model_last = w;
                pv[w] = 1'b0;
                outstanding = 1'b1;
                age = 0;
            end else begin
                chk("rnd_req0_ready", int'(req0_ready), 0);
                chk("rnd_req1_ready", int'(req1_ready), 0);
            end
            if (consumed) outstanding = 1'b0;
        end
        @(negedge clk);
        idle_inputs();
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        chk("rnd_drain_idle", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
